tpumac_pe: RTL and testbench

//  Parametrised multiply-accumulate processing element for the systolic array; successor to the basic MAC cell.

---
 rtl/tpumac_pe.sv | 86 ++++++++
 tb/tb_tpumac_pe.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tpumac_pe.sv
// tpumac_pe: systolic-array MAC processing element with optional product pipeline and saturating accumulate
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   clr             synchronous clear of Cout, ovf, busy and vout
//   WrEn            load Cout <= Cin (preload / C shift chain)
//   en              operand valid: forward Ain/Bin and accumulate Ain*Bin
//   Ain, Bin        signed operands from west / north neighbours
//   Cin             signed preload / shift-in value for C
//   Aout, Bout      registered operands to east / south neighbours
//   vout            registered en, qualifies Aout/Bout
//   Cout            accumulator
//   ovf             sticky overflow (saturation or wrap)
//   busy            product stage holds an unaccumulated product
module tpumac_pe #(
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int PIPE_MUL = 1,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               WrEn,
  input  logic               en,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic               vout,
  output logic [BITS_C-1:0]  Cout,
  output logic               ovf,
  output logic               busy
);
  localparam int PW = 2 * BITS_AB;
  localparam int SW = (PW > BITS_C ? PW : BITS_C) + 1;
  logic signed [PW-1:0] prod_c, prod_r, acc_in;
  logic signed [SW-1:0] sum;
  logic [SW-BITS_C:0]   top;
  logic                 acc_go, of;
  logic [BITS_C-1:0]    sat, nxt_c;
  always_comb begin
    prod_c = $signed(Ain) * $signed(Bin);
    acc_in = PIPE_MUL != 0 ? prod_r : prod_c;
    acc_go = PIPE_MUL != 0 ? busy : en;
    sum    = SW'($signed(Cout)) + SW'(acc_in);
    // the sum fits BITS_C exactly when every bit from the C sign bit upward agrees
    top    = sum[SW-1:BITS_C-1];
    of     = !(&top || !(|top));
    sat    = sum[SW-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    nxt_c  = (of && SATURATE != 0) ? sat : sum[BITS_C-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Aout   <= '0;
      Bout   <= '0;
      vout   <= 1'b0;
      Cout   <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      prod_r <= '0;
    end else if (clr) begin
      Cout <= '0;
      ovf  <= 1'b0;
      busy <= 1'b0;
      vout <= 1'b0;
    end else if (WrEn) begin
      Cout <= Cin;
      busy <= 1'b0;
      vout <= 1'b0;
    end else begin
      vout <= en;
      if (en) begin
        Aout <= Ain;
        Bout <= Bin;
      end
      if (acc_go) begin
        Cout <= nxt_c;
        if (of) ovf <= 1'b1;
      end
      // a pending product drains on this edge; a new one is captured only when en is high
      busy <= en && PIPE_MUL != 0;
      if (en && PIPE_MUL != 0) prod_r <= prod_c;
    end
  end
endmodule

// File: tb/tb_tpumac_pe.sv
// tb_tpumac_pe: directed vector bench for tpumac_pe in pipelined, wrapping and combinational configurations
module tb_tpumac_pe;
  logic        clk = 1'b0;
  logic        rst_n, clr, wr, en;
  logic [7:0]  a, b;
  logic [15:0] cin;
  logic [7:0]  ss_a, ss_b, sw_a, sw_b, cs_a, cs_b;
  logic [15:0] ss_c, sw_c, cs_c;
  logic        ss_v, ss_o, ss_bz, sw_v, sw_o, sw_bz, cs_v, cs_o, cs_bz;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  tpumac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE_MUL(1), .SATURATE(1)) u_ss (
    .clk(clk), .rst_n(rst_n), .clr(clr), .WrEn(wr), .en(en), .Ain(a), .Bin(b), .Cin(cin),
    .Aout(ss_a), .Bout(ss_b), .vout(ss_v), .Cout(ss_c), .ovf(ss_o), .busy(ss_bz));
  tpumac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE_MUL(1), .SATURATE(0)) u_sw (
    .clk(clk), .rst_n(rst_n), .clr(clr), .WrEn(wr), .en(en), .Ain(a), .Bin(b), .Cin(cin),
    .Aout(sw_a), .Bout(sw_b), .vout(sw_v), .Cout(sw_c), .ovf(sw_o), .busy(sw_bz));
  tpumac_pe #(.BITS_AB(8), .BITS_C(16), .PIPE_MUL(0), .SATURATE(1)) u_cs (
    .clk(clk), .rst_n(rst_n), .clr(clr), .WrEn(wr), .en(en), .Ain(a), .Bin(b), .Cin(cin),
    .Aout(cs_a), .Bout(cs_b), .vout(cs_v), .Cout(cs_c), .ovf(cs_o), .busy(cs_bz));

  typedef struct {
    logic clr, wr, en;
    int   a, b, cin;
    int   ea, eb;
    logic ev;
    int   ec;
    logic eo, ebz;
    int   ew, ecs;
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic e, input int av, input int bv, input int cv);
    clr = c;
    wr  = w;
    en  = e;
    a   = 8'(av);
    b   = 8'(bv);
    cin = 16'(cv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          clr wr en  a    b    cin     ea   eb   ev  ec     eo ebz  ew     ecs
    tv[0]  = '{0, 1, 0,   0,   0,  100,     0,   0, 0,  100,   0, 0,  100,   100};
    tv[1]  = '{0, 0, 1,   3,  -4,    0,     3,  -4, 1,  100,   0, 1,  100,    88};
    tv[2]  = '{0, 0, 0,   0,   0,    0,     3,  -4, 0,   88,   0, 0,   88,    88};
    tv[3]  = '{0, 0, 0,   0,   0,    0,     3,  -4, 0,   88,   0, 0,   88,    88};
    tv[4]  = '{0, 0, 1,   5,   5,    0,     5,   5, 1,   88,   0, 1,   88,   113};
    tv[5]  = '{0, 1, 0,   0,   0,    7,     5,   5, 0,    7,   0, 0,    7,     7};
    tv[6]  = '{0, 0, 0,   0,   0,    0,     5,   5, 0,    7,   0, 0,    7,     7};
    tv[7]  = '{0, 1, 1,   9,   9,    0,     5,   5, 0,    0,   0, 0,    0,     0};
    tv[8]  = '{1, 0, 0,   0,   0,    0,     5,   5, 0,    0,   0, 0,    0,     0};
    tv[9]  = '{0, 0, 1,   1,   2,    0,     1,   2, 1,    0,   0, 1,    0,     2};
    tv[10] = '{0, 0, 1,   2,   2,    0,     2,   2, 1,    2,   0, 1,    2,     6};
    tv[11] = '{0, 0, 1,   3,   2,    0,     3,   2, 1,    6,   0, 1,    6,    12};
    tv[12] = '{0, 0, 1,   4,   2,    0,     4,   2, 1,   12,   0, 1,   12,    20};
    tv[13] = '{0, 0, 0,   0,   0,    0,     4,   2, 0,   20,   0, 0,   20,    20};
    tv[14] = '{0, 1, 0,   0,   0, -32000,   4,   2, 0, -32000, 0, 0, -32000, -32000};
    tv[15] = '{0, 0, 1, -128, 127,   0,  -128, 127, 1, -32000, 0, 1, -32000, -32768};
    tv[16] = '{0, 0, 1,   1,   1,    0,     1,   1, 1, -32768, 1, 1,  17280, -32767};
    tv[17] = '{0, 0, 0,   0,   0,    0,     1,   1, 0, -32767, 1, 0,  17281, -32767};
    tv[18] = '{1, 0, 0,   0,   0,    0,     1,   1, 0,    0,   0, 0,    0,     0};

    rst_n = 1'b0;
    clr = 0; wr = 0; en = 1; a = 8'd7; b = 8'd7; cin = 16'd0;
    #12;
    chk("reset Aout", $signed(ss_a), 0);
    chk("reset vout", int'(ss_v), 0);
    chk("reset Cout", $signed(ss_c), 0);
    chk("reset ovf", int'(ss_o), 0);
    chk("reset busy", int'(ss_bz), 0);
    en = 0; a = 0; b = 0;
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 19; i++) begin
      step(tv[i].clr, tv[i].wr, tv[i].en, tv[i].a, tv[i].b, tv[i].cin);
      chk($sformatf("v%0d Aout", i), $signed(ss_a), tv[i].ea);
      chk($sformatf("v%0d Bout", i), $signed(ss_b), tv[i].eb);
      chk($sformatf("v%0d vout", i), int'(ss_v), int'(tv[i].ev));
      chk($sformatf("v%0d Cout", i), $signed(ss_c), tv[i].ec);
      chk($sformatf("v%0d ovf", i), int'(ss_o), int'(tv[i].eo));
      chk($sformatf("v%0d busy", i), int'(ss_bz), int'(tv[i].ebz));
      chk($sformatf("v%0d wrap Cout", i), $signed(sw_c), tv[i].ew);
      chk($sformatf("v%0d comb Cout", i), $signed(cs_c), tv[i].ecs);
      chk($sformatf("v%0d comb busy", i), int'(cs_bz), 0);
    end

    step(0, 1, 0, 0, 0, 32000);
    step(0, 0, 1, 127, 127, 0);
    chk("sat+ comb Cout", $signed(cs_c), 32767);
    chk("sat+ comb ovf", int'(cs_o), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("sat+ Cout", $signed(ss_c), 32767);
    chk("sat+ ovf", int'(ss_o), 1);
    chk("wrap+ Cout", $signed(sw_c), -17407);
    chk("wrap+ ovf", int'(sw_o), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("clr Cout", $signed(ss_c), 0);
    chk("clr ovf", int'(ss_o), 0);
    chk("clr wrap ovf", int'(sw_o), 0);

    step(0, 0, 1, 2, 3, 0);
    step(0, 0, 1, 2, 3, 0);
    step(0, 0, 1, 2, 3, 0);
    chk("pre-rst Cout", $signed(ss_c), 12);
    chk("pre-rst busy", int'(ss_bz), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst Aout", $signed(ss_a), 0);
    chk("mid rst Bout", $signed(ss_b), 0);
    chk("mid rst vout", int'(ss_v), 0);
    chk("mid rst Cout", $signed(ss_c), 0);
    chk("mid rst busy", int'(ss_bz), 0);
    en = 0; a = 0; b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post rst Cout", $signed(ss_c), 0);
    chk("post rst comb Cout", $signed(cs_c), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("post rst Cout2", $signed(ss_c), 0);
    chk("post rst busy", int'(ss_bz), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
